// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : Streaming FIFO controller for an external dual-port SRAM.
//               Port a carries writes, port b carries reads. A 2-entry
//               prefetch buffer hides the SRAM's one-cycle read latency so
//               both sides sustain one word per clock.
//               Optional macro RAM_FIFO_WATERMARK_EN builds the registered
//               almost_full flag; without it almost_full is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int AFULL_LEVEL = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  almost_full,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic                  ram_wr_a,
    output logic [DATA_WIDTH-1:0] ram_wdata_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic                  ram_rd_b,
    input  logic [DATA_WIDTH-1:0] ram_rdata_b
);

    localparam int                PW      = ADDR_WIDTH + 1;
    localparam int                LW      = ADDR_WIDTH + 2;
    localparam logic [PW-1:0]     c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Threshold must be reachable by level (max DEPTH + 2 words held).
    if ((AFULL_LEVEL < 1) || (AFULL_LEVEL > (1 << ADDR_WIDTH) + 2)) begin : g_bad_afull
        $error("ram_fifo_ctrl: AFULL_LEVEL out of range");
    end

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic                  r_inflight;
    logic [1:0]            r_buf_cnt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [LW-1:0]         r_level;

    logic [PW-1:0]         w_ram_count;
    logic                  w_wr_fire;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic                  w_fetch;
    logic                  w_capture;
    logic [1:0]            w_cnt_after_pop;
    logic [PW-1:0]         w_wr_ptr_nxt;
    logic [PW-1:0]         w_rd_ptr_nxt;
    logic [1:0]            w_buf_cnt_nxt;
    logic [PW-1:0]         w_ram_count_nxt;
    logic [LW-1:0]         w_level_nxt;

    // Words still sitting in the SRAM (not yet fetched); the pointer MSB
    // separates the full case (DEPTH) from empty (0).
    assign w_ram_count = r_wr_ptr - r_rd_ptr;

    assign wr_ready    = ~rst & ~clear & (w_ram_count < c_depth);
    assign w_wr_fire   = wr_valid & wr_ready;
    assign ram_wr_a    = w_wr_fire;
    assign ram_addr_a  = r_wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wdata_a = wr_data;

    assign rd_valid    = (r_buf_cnt != 2'd0);
    assign rd_data     = r_head;
    assign w_pop       = rd_valid & rd_ready;

    // Buffer occupancy one edge from now, counting the word in flight as
    // already landed; a fetch is allowed only if its word will fit.
    assign w_occ      = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_fetch    = (w_ram_count != '0) & (w_occ < 3'd2) & ~clear;
    assign ram_rd_b   = w_fetch;
    assign ram_addr_b = r_rd_ptr[ADDR_WIDTH-1:0];

    // A read returning during clear belongs to flushed contents.
    assign w_capture       = r_inflight & ~clear;
    assign w_cnt_after_pop = r_buf_cnt - {1'b0, w_pop};

    assign w_wr_ptr_nxt    = clear ? '0 : r_wr_ptr + PW'(w_wr_fire);
    assign w_rd_ptr_nxt    = clear ? '0 : r_rd_ptr + PW'(w_fetch);
    assign w_buf_cnt_nxt   = clear ? 2'd0 : w_occ[1:0];
    assign w_ram_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_level_nxt     = LW'(w_ram_count_nxt) + LW'(w_fetch) + LW'(w_buf_cnt_nxt);

    assign level = r_level;

    // Pointer, in-flight flag, occupancy and level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_buf_cnt  <= 2'd0;
            r_level    <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_inflight <= w_fetch;
            r_buf_cnt  <= w_buf_cnt_nxt;
            r_level    <= w_level_nxt;
        end
    end

    // Prefetch buffer data: pop shifts tail into head, capture lands in the
    // first slot left free after the pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (!clear) begin
            if (w_pop) begin
                r_head <= r_tail;
            end
            if (w_capture) begin
                if (w_cnt_after_pop == 2'd0) begin
                    r_head <= ram_rdata_b;
                end else begin
                    r_tail <= ram_rdata_b;
                end
            end
        end
    end

`ifdef RAM_FIFO_WATERMARK_EN
    localparam logic [LW-1:0] c_afull = LW'(AFULL_LEVEL);
    logic r_almost_full;

    // Watermark flag tracks the level being loaded this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_level_nxt >= c_afull);
        end
    end

    assign almost_full = r_almost_full;
`else
    assign almost_full = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_fifo_ctrl
// Description : Scoreboard bench for ram_fifo_ctrl with a behavioural SRAM.
//               The reference model is an ordered queue of accepted words;
//               the expected level is simply words accepted minus words
//               delivered, with clear/reset emptying everything.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int AFULL = 1000;
`ifdef RAM_FIFO_WATERMARK_EN
    localparam bit WM = 1'b1;
`else
    localparam bit WM = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          clear;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW+1:0] level;
    logic          almost_full;
    logic [AW-1:0] ram_addr_a;
    logic          ram_wr_a;
    logic [DW-1:0] ram_wdata_a;
    logic [AW-1:0] ram_addr_b;
    logic          ram_rd_b;
    logic [DW-1:0] ram_rdata_b;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_LEVEL(AFULL)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level), .almost_full(almost_full),
        .ram_addr_a(ram_addr_a), .ram_wr_a(ram_wr_a), .ram_wdata_a(ram_wdata_a),
        .ram_addr_b(ram_addr_b), .ram_rd_b(ram_rd_b), .ram_rdata_b(ram_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM with registered read port.
    always @(posedge clk) begin
        if (ram_wr_a) mem[ram_addr_a] <= ram_wdata_a;
        if (ram_rd_b) ram_rdata_b <= mem[ram_addr_b];
    end

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] exp_q [$];
    int            exp_level = 0;
    int            n_push = 0;
    int            n_pop  = 0;
    logic          s_rv;
    logic [DW-1:0] s_rd;
    int            s_level;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Monitor: pops and compares on every delivered word, tracks level.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_level = 0;
        end else begin
            check("level", 64'(level), 64'(exp_level));
            check("almost_full", 64'(almost_full), 64'(WM && (exp_level >= AFULL)));
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_extra: got %0h expected no word", rd_data);
                end else begin
                    check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
                end
                n_pop++;
            end
            exp_level = exp_level + int'(wr_valid && wr_ready) - int'(rd_valid && rd_ready);
            if (clear) begin
                exp_q.delete();
                exp_level = 0;
            end
        end
    end

    // One clock: record the handshake at the negedge, then step past the edge.
    task automatic tick();
        @(negedge clk);
        s_rv    = rd_valid;
        s_rd    = rd_data;
        s_level = int'(level);
        if (wr_valid && wr_ready) begin
            exp_q.push_back(wr_data);
            n_push++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        n = 0;
        while ((level != '0 || rd_valid) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) timeout(name);
        tick();
        check({name, "_level"}, 64'(level), 64'd0);
        check({name, "_qempty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int acc0, gaps, popped, maxlvl, n;
        bit seen;
        rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_wr_ready", 64'(wr_ready), 64'd1);

        // Single word latency.
        rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 32'hA5A5_0001;
        tick();
        wr_valid = 1'b0;
        tick(); check("lat_c1_valid", 64'(s_rv), 64'd0);
        tick(); check("lat_c2_valid", 64'(s_rv), 64'd0);
        tick(); check("lat_c3_valid", 64'(s_rv), 64'd1);
        check("lat_c3_data", 64'(s_rd), 64'hA5A5_0001);
        tick(); tick();
        check("single_level", 64'(level), 64'd0);

        // Back-to-back streaming.
        acc0 = n_push; gaps = 0; popped = 0; maxlvl = 0; seen = 1'b0; n = 0;
        rd_ready = 1'b1;
        while (popped < 4096 && n < 4300) begin
            wr_valid = (n < 4096);
            wr_data  = DW'(n);
            tick();
            if (s_rv) seen = 1'b1;
            if (seen && !s_rv && popped < 4096) gaps++;
            if (s_rv) popped++;
            if (s_level > maxlvl) maxlvl = s_level;
            n++;
        end
        if (popped < 4096) timeout("stream");
        check("stream_accepted", 64'(n_push - acc0), 64'd4096);
        check("stream_gaps", 64'(gaps), 64'd0);
        check("stream_maxlvl_le3", 64'(maxlvl <= 3), 64'd1);
        drain("stream_drain");

        // Fill until full with the consumer stalled.
        acc0 = n_push;
        rd_ready = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h1000_0000 + DW'(n_push - acc0);
            tick();
        end
        wr_valid = 1'b0;
        check("fill_accepted", 64'(n_push - acc0), 64'd1026);
        check("fill_level", 64'(level), 64'd1026);
        check("fill_wr_ready", 64'(wr_ready), 64'd0);
        check("fill_almost_full", 64'(almost_full), 64'(WM));
        drain("fill_drain");

        // Random backpressure with continuous writes.
        acc0 = n_push; n = 0;
        while ((n_push - acc0) < 10000 && n < 40000) begin
            wr_valid = 1'b1;
            wr_data  = DW'($urandom);
            rd_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (n >= 40000) timeout("bp");
        drain("bp_drain");

        // Clear while a read is in flight and the buffer is occupied.
        rd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hC0 + DW'(k);
            tick();
        end
        check("pre_clear_level", 64'(level), 64'd3);
        wr_valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_rd_valid", 64'(rd_valid), 64'd0);
        check("clear_level", 64'(level), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("clear_no_late", 64'(s_rv), 64'd0);
        end
        rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 32'h1234;
        tick();
        wr_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!s_rv && n < 10);
        check("clear_readback", 64'(s_rd), 64'h1234);
        drain("clear_drain");

        // Asynchronous reset mid-operation.
        rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hD000 + DW'(k);
            tick();
        end
        wr_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_rd_valid", 64'(rd_valid), 64'd0);
        check("arst_rd_data", 64'(rd_data), 64'd0);
        check("arst_level", 64'(level), 64'd0);
        check("arst_wr_ready", 64'(wr_ready), 64'd0);
        check("arst_ram_wr_a", 64'(ram_wr_a), 64'd0);
        check("arst_ram_rd_b", 64'(ram_rd_b), 64'd0);
        check("arst_addr", 64'({ram_addr_a, ram_addr_b}), 64'd0);
        check("arst_almost_full", 64'(almost_full), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_release_wr_ready", 64'(wr_ready), 64'd1);
        for (int k = 0; k < 20; k++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hBEEF_0000 + DW'(k);
            rd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain("arst_drain");

        check("push_pop_balance", 64'(n_pop), 64'(n_push - 3 - 5));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
